// File: rtl/lm32_itlb_walker_if.sv
// Wishbone read-only master bus between the ITLB walker and the page-table memory.
//   adr  : byte address of the PTE being fetched (walker -> memory)
//   cyc  : bus cycle in progress (walker -> memory)
//   stb  : strobe, mirrors cyc for this single-beat master (walker -> memory)
//   dat  : PTE read data (memory -> walker)
//   ack  : transfer acknowledge (memory -> walker)
//   err  : transfer error (memory -> walker)
interface lm32_itlb_walker_if;
  logic [31:0] adr;
  logic        cyc;
  logic        stb;
  logic [31:0] dat;
  logic        ack;
  logic        err;

  modport master (output adr, cyc, stb, input dat, ack, err);
  modport slave  (input adr, cyc, stb, output dat, ack, err);
endinterface

// File: rtl/lm32_itlb_walker.sv
// ITLB refill engine. On an ITLB miss it reads one PTE from a flat single-level
// page table over Wishbone and writes the VPFN->PFN mapping into the ITLB.
// Unusable entries, bus errors, bus timeouts and a disabled walker are reported
// with a fault code instead.
// Ports:
//   clk_i, rst_i          clock, synchronous active-high reset
//   enable_i              walker enabled, sampled when a miss is accepted
//   miss_i, miss_vaddr_i  miss request (held until done_o/fault_o) and its address
//   pt_base_i             page-table base byte address, bits [1:0] ignored
//   wb                    Wishbone master (adr/cyc/stb out, dat/ack/err in)
//   upd_vaddr_o/paddr_o   ITLB update addresses, valid while upd_we_o is high
//   upd_we_o              one-cycle ITLB update strobe
//   busy_o                walker not idle
//   done_o, fault_o       4-phase completion levels, never both high
//   fault_code_o          00 disabled, 01 PTE invalid, 10 bus error, 11 timeout
module lm32_itlb_walker #(
  parameter int page_size     = 4096,
  parameter int timeout_width = 8
) (
  input  logic               clk_i,
  input  logic               rst_i,
  input  logic               enable_i,
  input  logic               miss_i,
  input  logic [31:0]        miss_vaddr_i,
  input  logic [31:0]        pt_base_i,
  lm32_itlb_walker_if.master wb,
  output logic [31:0]        upd_vaddr_o,
  output logic [31:0]        upd_paddr_o,
  output logic               upd_we_o,
  output logic               busy_o,
  output logic               done_o,
  output logic               fault_o,
  output logic [1:0]         fault_code_o
);
  localparam int PG = $clog2(page_size);
  localparam int VW = 32 - PG;
  localparam logic [timeout_width-1:0] CNT_ONE  = 1;
  // Leaving REQ as the counter steps to all-ones bounds the bus cycle to 2**w-1 cycles.
  localparam logic [timeout_width-1:0] CNT_LAST = {{(timeout_width-1){1'b1}}, 1'b0};

  localparam logic [1:0] CODE_DISABLED = 2'b00;
  localparam logic [1:0] CODE_INVALID  = 2'b01;
  localparam logic [1:0] CODE_BUSERR   = 2'b10;
  localparam logic [1:0] CODE_TIMEOUT  = 2'b11;

  typedef enum logic [1:0] {IDLE, REQ, UPDATE, RESP} state_t;

  state_t                   state, state_n;
  logic [timeout_width-1:0] cnt;
  logic                     flt_r, flt_n;
  logic [1:0]               code_r, code_n;
  logic                     accept, latch_pte;

  logic [31:0]              adr_r;
  logic [VW-1:0]            vpfn_r;
  logic [VW-1:0]            pfn_r;
  logic [31:0]              pt_off;
  logic                     unused_bits;

  // Table index scaled to a word offset; the sum below wraps silently at 2**32.
  assign pt_off      = {{(PG-2){1'b0}}, miss_vaddr_i[31:PG], 2'b00};
  assign unused_bits = ^{miss_vaddr_i[PG-1:0], pt_base_i[1:0], wb.dat[PG-1:1]};

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state  <= IDLE;
      cnt    <= '0;
      flt_r  <= 1'b0;
      code_r <= CODE_DISABLED;
    end else begin
      state  <= state_n;
      flt_r  <= flt_n;
      code_r <= code_n;
      if (accept)
        cnt <= '0;
      else if (state == REQ)
        cnt <= cnt + CNT_ONE;
    end
  end

  // Request and PTE payload registers carry no reset; every output that shows
  // them is gated by the state, which is reset.
  always_ff @(posedge clk_i) begin
    if (accept) begin
      adr_r  <= {pt_base_i[31:2], 2'b00} + pt_off;
      vpfn_r <= miss_vaddr_i[31:PG];
    end
    if (latch_pte)
      pfn_r <= wb.dat[31:PG];
  end

  always_comb begin
    state_n   = state;
    flt_n     = flt_r;
    code_n    = code_r;
    accept    = 1'b0;
    latch_pte = 1'b0;
    case (state)
      IDLE: begin
        if (miss_i) begin
          if (enable_i) begin
            state_n = REQ;
            accept  = 1'b1;
            flt_n   = 1'b0;
            code_n  = CODE_DISABLED;
          end else begin
            state_n = RESP;
            flt_n   = 1'b1;
            code_n  = CODE_DISABLED;
          end
        end
      end
      REQ: begin
        // err wins over a simultaneous ack.
        if (wb.err) begin
          state_n = RESP;
          flt_n   = 1'b1;
          code_n  = CODE_BUSERR;
        end else if (wb.ack) begin
          if (wb.dat[0]) begin
            state_n   = UPDATE;
            latch_pte = 1'b1;
          end else begin
            state_n = RESP;
            flt_n   = 1'b1;
            code_n  = CODE_INVALID;
          end
        end else if (cnt == CNT_LAST) begin
          state_n = RESP;
          flt_n   = 1'b1;
          code_n  = CODE_TIMEOUT;
        end
      end
      UPDATE: begin
        state_n = RESP;
      end
      RESP: begin
        if (!miss_i)
          state_n = IDLE;
      end
      default: state_n = IDLE;
    endcase
  end

  assign busy_o       = (state != IDLE);
  assign wb.cyc       = (state == REQ);
  assign wb.stb       = (state == REQ);
  assign wb.adr       = (state == REQ) ? adr_r : 32'h0;
  assign upd_we_o     = (state == UPDATE);
  assign upd_vaddr_o  = upd_we_o ? {vpfn_r, {PG{1'b0}}} : 32'h0;
  assign upd_paddr_o  = upd_we_o ? {pfn_r, {PG{1'b0}}} : 32'h0;
  assign done_o       = (state == RESP) && !flt_r;
  assign fault_o      = (state == RESP) && flt_r;
  assign fault_code_o = fault_o ? code_r : 2'b00;
endmodule

// File: tb/tb_lm32_itlb_walker.sv
module tb_lm32_itlb_walker;
  logic        clk_i = 1'b0;
  logic        rst_i;
  logic        enable_i, miss_i;
  logic [31:0] miss_vaddr_i, pt_base_i;
  logic [31:0] upd_vaddr_o, upd_paddr_o;
  logic        upd_we_o, busy_o, done_o, fault_o;
  logic [1:0]  fault_code_o;

  always #5 clk_i = ~clk_i;

  lm32_itlb_walker_if wb ();

  lm32_itlb_walker #(.page_size(4096), .timeout_width(8)) dut (
    .clk_i       (clk_i),
    .rst_i       (rst_i),
    .enable_i    (enable_i),
    .miss_i      (miss_i),
    .miss_vaddr_i(miss_vaddr_i),
    .pt_base_i   (pt_base_i),
    .wb          (wb),
    .upd_vaddr_o (upd_vaddr_o),
    .upd_paddr_o (upd_paddr_o),
    .upd_we_o    (upd_we_o),
    .busy_o      (busy_o),
    .done_o      (done_o),
    .fault_o     (fault_o),
    .fault_code_o(fault_code_o)
  );

  typedef struct {
    logic [31:0] base, vaddr, pte;
    logic        en, respond, ack, err;
    int          delay;     // stb cycle (1-based) on which ack/err is driven
    logic [31:0] adr, uv, up;
    logic        bus, done, upd;
    logic [1:0]  code;
    int          resp_idx;  // busy cycle in which done/fault first appears
    int          cyc_len;   // cycles with cyc high
  } vec_t;

  vec_t sb[$];
  vec_t vecs[8];
  int   checks = 0;
  int   passes = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  function automatic vec_t mk(input logic [31:0] base, vaddr, input logic en, respond, ack, err,
                              input int delay, input logic [31:0] pte, adr, uv, up,
                              input logic bus, done, upd, input logic [1:0] code,
                              input int resp_idx, cyc_len);
    vec_t v;
    v.base = base; v.vaddr = vaddr; v.en = en; v.respond = respond; v.ack = ack; v.err = err;
    v.delay = delay; v.pte = pte; v.adr = adr; v.uv = uv; v.up = up; v.bus = bus;
    v.done = done; v.upd = upd; v.code = code; v.resp_idx = resp_idx; v.cyc_len = cyc_len;
    return v;
  endfunction

  // Monitor: observes one walk per busy period and compares against the scoreboard.
  int          idx, cyc_len, upd_cnt, upd_idx;
  logic        bus_seen, resp_seen, stb_bad;
  logic [31:0] adr_seen, uv_seen, up_seen;

  always @(negedge clk_i) begin
    vec_t e;
    if (rst_i || !busy_o) begin
      idx = 0; cyc_len = 0; upd_cnt = 0; upd_idx = 0;
      bus_seen = 1'b0; resp_seen = 1'b0; stb_bad = 1'b0;
    end else begin
      idx++;
      if (wb.cyc) begin
        if (!bus_seen) begin
          bus_seen = 1'b1;
          adr_seen = wb.adr;
        end
        cyc_len++;
      end
      if (wb.stb !== wb.cyc) stb_bad = 1'b1;
      if (upd_we_o) begin
        upd_cnt++;
        upd_idx = idx;
        uv_seen = upd_vaddr_o;
        up_seen = upd_paddr_o;
      end
      if ((done_o || fault_o) && !resp_seen) begin
        resp_seen = 1'b1;
        if (sb.size() == 0) begin
          checks++;
          $display("FAIL unexpected_resp: got done=%0b fault=%0b with no walk pending", done_o, fault_o);
        end else begin
          e = sb.pop_front();
          chk("resp_idx", 32'(idx), 32'(e.resp_idx));
          chk("done", 32'(done_o), 32'(e.done));
          chk("fault", 32'(fault_o), 32'(!e.done));
          chk("code", 32'(fault_code_o), e.done ? 32'h0 : 32'(e.code));
          chk("bus_used", 32'(bus_seen), 32'(e.bus));
          chk("cyc_len", 32'(cyc_len), 32'(e.cyc_len));
          chk("stb_eq_cyc", 32'(stb_bad), 32'h0);
          if (e.bus) chk("adr", adr_seen, e.adr);
          chk("upd_count", 32'(upd_cnt), 32'(e.upd));
          if (e.upd) begin
            chk("upd_idx", 32'(upd_idx), 32'(e.resp_idx - 1));
            chk("upd_vaddr", uv_seen, e.uv);
            chk("upd_paddr", up_seen, e.up);
          end
        end
      end
    end
  end

  task automatic run_walk(input vec_t v);
    int   scnt = 0;
    bit   got  = 0;
    logic ok;
    sb.push_back(v);
    @(negedge clk_i);
    pt_base_i = v.base; miss_vaddr_i = v.vaddr; enable_i = v.en; miss_i = 1'b1;
    for (int c = 0; c < 400 && !got; c++) begin
      @(negedge clk_i);
      wb.ack = 1'b0; wb.err = 1'b0; wb.dat = 32'h0;
      if (done_o || fault_o) got = 1;
      else if (wb.cyc) begin
        scnt++;
        if (v.respond && scnt == v.delay) begin
          wb.ack = v.ack; wb.err = v.err; wb.dat = v.pte;
        end
      end
    end
    if (!got) begin
      checks++;
      $display("FAIL walk_timeout: got no done/fault within 400 cycles, required a response");
    end else begin
      // Miss held high after completion: result must stay, no second bus cycle.
      ok = 1'b1;
      repeat (5) begin
        @(negedge clk_i);
        if (done_o !== v.done || fault_o !== !v.done ||
            fault_code_o !== (v.done ? 2'b00 : v.code) || wb.cyc !== 1'b0 || upd_we_o !== 1'b0)
          ok = 1'b0;
      end
      chk("hold_while_miss", 32'(ok), 32'h1);
    end
    miss_i = 1'b0;
    @(negedge clk_i);
    chk("release", 32'({busy_o, done_o, fault_o}), 32'h0);
  endtask

  initial begin
    rst_i = 1'b1; enable_i = 1'b0; miss_i = 1'b0;
    miss_vaddr_i = 32'h0; pt_base_i = 32'h0;
    wb.ack = 1'b0; wb.err = 1'b0; wb.dat = 32'h0;
    repeat (3) @(negedge clk_i);
    chk("reset_outs", 32'(|{wb.cyc, wb.stb, wb.adr, busy_o, done_o, fault_o, upd_we_o,
                            upd_vaddr_o, upd_paddr_o, fault_code_o}), 32'h0);
    rst_i = 1'b0;
    @(negedge clk_i);

    //          base          vaddr        en r  a  e  dly pte            adr            uv             up             bus dn upd code  idx cyc
    vecs[0] = mk(32'h4000_0000, 32'h0001_2345, 1, 1, 1, 0, 3, 32'h8765_4001, 32'h4000_0048, 32'h0001_2000, 32'h8765_4000, 1, 1, 1, 2'b00, 5, 3);
    vecs[1] = mk(32'h4000_0000, 32'h0001_2345, 1, 1, 1, 0, 3, 32'h8765_4000, 32'h4000_0048, 32'h0, 32'h0, 1, 0, 0, 2'b01, 4, 3);
    vecs[2] = mk(32'h4000_0000, 32'h0001_2345, 1, 1, 1, 1, 2, 32'h8765_4001, 32'h4000_0048, 32'h0, 32'h0, 1, 0, 0, 2'b10, 3, 2);
    vecs[3] = mk(32'h4000_0000, 32'h0001_2345, 1, 0, 0, 0, 0, 32'h0, 32'h4000_0048, 32'h0, 32'h0, 1, 0, 0, 2'b11, 256, 255);
    vecs[4] = mk(32'h4000_0000, 32'h0001_2345, 0, 0, 0, 0, 0, 32'h0, 32'h0, 32'h0, 32'h0, 0, 0, 0, 2'b00, 1, 0);
    vecs[5] = mk(32'hFFFF_FFF0, 32'h0000_5000, 1, 1, 1, 0, 1, 32'h0000_1001, 32'h0000_0004, 32'h0000_5000, 32'h0000_1000, 1, 1, 1, 2'b00, 3, 1);
    vecs[6] = mk(32'h1000_0003, 32'hFFFF_FFFF, 1, 1, 1, 0, 5, 32'hABCD_EFFF, 32'h103F_FFFC, 32'hFFFF_F000, 32'hABCD_E000, 1, 1, 1, 2'b00, 7, 5);
    vecs[7] = mk(32'h2000_0000, 32'h0000_0000, 1, 1, 0, 1, 1, 32'h8765_4001, 32'h2000_0000, 32'h0, 32'h0, 1, 0, 0, 2'b10, 2, 1);

    for (int i = 0; i < 8; i++) run_walk(vecs[i]);

    // Reset in the middle of a bus cycle: everything drops, no update or response.
    @(negedge clk_i);
    pt_base_i = 32'h4000_0000; miss_vaddr_i = 32'h0001_2345; enable_i = 1'b1; miss_i = 1'b1;
    repeat (3) @(negedge clk_i);
    chk("req_before_rst", 32'({wb.cyc, wb.stb, busy_o}), 32'h7);
    rst_i = 1'b1;
    @(negedge clk_i);
    chk("rst_mid_req", 32'(|{wb.cyc, wb.stb, wb.adr, busy_o, done_o, fault_o, upd_we_o,
                             upd_vaddr_o, upd_paddr_o, fault_code_o}), 32'h0);
    miss_i = 1'b0;
    @(negedge clk_i);
    rst_i = 1'b0;
    @(negedge clk_i);

    // A normal walk still works after the reset.
    run_walk(vecs[0]);
    chk("sb_empty", 32'(sb.size()), 32'h0);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end
endmodule
